// File: rtl/rs232_pkg.sv
// rs232_pkg: shared encodings, line levels and bit-period helper for the RS232 transmitter and receiver.
package rs232_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    function automatic int calc_bit_per(input int mhz, input int baud);
        return (mhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/rs232_baud_tick.sv
// rs232_baud_tick: free-running bit-period counter with synchronous clear and a tick on the last count.
module rs232_baud_tick #(
    parameter int bit_per = 4
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int W = (bit_per > 1) ? $clog2(bit_per) : 1;
    localparam logic [W-1:0] LAST = W'(bit_per - 1);

    logic [W-1:0] r_count;

    assign o_tick = (r_count == LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_count <= '0;
        else            r_count <= (i_clear || o_tick) ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/rs232_tx.sv
// rs232_tx: 8N1/8N2 serial transmitter with a one-deep holding register feeding a start/data/stop FSM.
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int baud      = 9600,
    parameter int mhz       = 50,
    parameter int stop_bits = 1,
    parameter int invert    = 0
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_rs232_dce_txd
);

    localparam int   BIT_PER   = calc_bit_per(mhz, baud);
    localparam logic INV       = (invert != 0);
    localparam logic LAST_STOP = 1'(stop_bits - 1);

    if (BIT_PER < 2) begin : g_bad_rate
        $error("rs232_tx: bit_per must be at least 2");
    end
    if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
        $error("rs232_tx: stop_bits must be 1 or 2");
    end

    state_t     r_state;
    logic [7:0] r_hold;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_txd;
    logic       w_tick;
    logic       w_clear;

    assign w_clear         = (r_state == IDLE);
    assign o_tx_ready      = r_ready;
    assign o_tx_busy       = r_busy;
    assign o_tx_done       = r_done;
    assign o_rs232_dce_txd = r_txd;

    rs232_baud_tick #(.bit_per(BIT_PER)) u_baud_tick (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .o_tick    (w_tick)
    );

    // The line register is loaded with the level of the state being entered, so each bit appears on the edge it starts.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_txd      <= IDLE_LVL ^ INV;
        end else begin
            r_done <= 1'b0;
            if (i_tx_valid && r_ready) begin
                r_hold  <= i_tx_data;
                r_ready <= 1'b0;
            end
            case (r_state)
                IDLE: if (!r_ready) begin
                    r_shift <= r_hold;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= START;
                    r_txd   <= START_LVL ^ INV;
                end
                START: if (w_tick) begin
                    r_bit_cnt <= '0;
                    r_state   <= DATA;
                    r_txd     <= r_shift[0] ^ INV;
                end
                DATA: if (w_tick) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_stop_cnt <= 1'b0;
                        r_state    <= STOP;
                        r_txd      <= STOP_LVL ^ INV;
                    end else begin
                        r_txd <= r_shift[1] ^ INV;
                    end
                end
                STOP: if (w_tick) begin
                    if (r_stop_cnt == LAST_STOP) begin
                        r_done <= 1'b1;
                        if (!r_ready) begin
                            r_shift <= r_hold;
                            r_ready <= 1'b1;
                            r_state <= START;
                            r_txd   <= START_LVL ^ INV;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                            r_txd   <= IDLE_LVL ^ INV;
                        end
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// tb_rs232_tx: three transmitter configurations checked cycle by cycle against a frame-position reference model.
module tb_rs232_tx;

    localparam int BP = 1_000_000 / 250_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  [3];
    logic [7:0] data   [3];
    logic       valid  [3];
    logic       w_ready[3];
    logic       w_busy [3];
    logic       w_done [3];
    logic       w_txd  [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level from the position inside a frame: bit index = position / bit period.
    function automatic logic [31:0] lvl(input int p, input logic [7:0] b, input int inv);
        int   i;
        logic l;
        if (p < 0) l = 1'b1;
        else begin
            i = p / BP;
            l = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : 1'b1;
        end
        return {31'b0, l ^ inv[0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SB  = (g == 1) ? 2 : 1;
        localparam int INV = (g == 2) ? 1 : 0;
        localparam int FL  = (9 + SB) * BP;

        rs232_tx #(.baud(250000), .mhz(1), .stop_bits(SB), .invert(INV)) dut (
            .i_clock         (clk),
            .i_reset_n       (rst_n[g]),
            .i_tx_data       (data[g]),
            .i_tx_valid      (valid[g]),
            .o_tx_ready      (w_ready[g]),
            .o_tx_busy       (w_busy[g]),
            .o_tx_done       (w_done[g]),
            .o_rs232_dce_txd (w_txd[g])
        );

        logic [7:0] q[$];
        logic [7:0] cur;
        int         pos;
        logic       m_done;
        logic       acc;

        initial begin
            pos    = -1;
            m_done = 1'b0;
            cur    = '0;
            forever begin
                @(negedge clk);
                if (!rst_n[g]) begin
                    q.delete();
                    pos    = -1;
                    m_done = 1'b0;
                end
                check($sformatf("d%0d_txd", g),   w_txd[g],   lvl(pos, cur, INV));
                check($sformatf("d%0d_busy", g),  w_busy[g],  pos >= 0);
                check($sformatf("d%0d_ready", g), w_ready[g], q.size() == 0);
                check($sformatf("d%0d_done", g),  w_done[g],  m_done);
                if (rst_n[g]) begin
                    acc    = valid[g] && (q.size() == 0);
                    m_done = (pos == FL - 1);
                    if (pos >= 0 && pos < FL - 1) pos++;
                    else if (q.size() > 0) begin
                        cur = q.pop_front();
                        pos = 0;
                    end else pos = -1;
                    if (acc) q.push_back(data[g]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input int g, input logic [7:0] b);
        data[g]  = b;
        valid[g] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (w_ready[g]) begin
                @(posedge clk);
                #2;
                valid[g] = 1'b0;
                return;
            end
        end
        check($sformatf("d%0d_accept_timeout", g), 0, 1);
        valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!w_busy[g] && w_ready[g]) begin
                idle(1);
                return;
            end
        end
        check($sformatf("d%0d_idle_timeout", g), 0, 1);
    endtask

    task automatic run_rand(input int g);
        for (int k = 0; k < 10; k++) begin
            idle($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 50));
            send(g, 8'($urandom));
        end
        wait_idle(g);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b1;
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        idle(2);

        send(0, 8'hA5);
        wait_idle(0);
        send(0, 8'h00);
        send(0, 8'hFF);
        wait_idle(0);

        send(0, 8'h3C);
        send(0, 8'hC3);
        data[0]  = 8'h99;
        valid[0] = 1'b1;
        idle(1);
        valid[0] = 1'b0;
        data[0]  = 8'h11;
        wait_idle(0);

        send(0, 8'h55);
        send(0, 8'hAA);
        idle(12);
        @(negedge clk);
        #1;
        rst_n[0] = 1'b0;
        #1;
        check("rst_mid_txd",   w_txd[0],   1);
        check("rst_mid_ready", w_ready[0], 1);
        check("rst_mid_busy",  w_busy[0],  0);
        check("rst_mid_done",  w_done[0],  0);
        repeat (2) @(negedge clk);
        #1;
        rst_n[0] = 1'b1;
        idle(60);

        send(1, 8'h3C);
        wait_idle(1);
        send(2, 8'h01);
        wait_idle(2);
        idle(5);

        fork
            run_rand(0);
            run_rand(1);
            run_rand(2);
        join
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
